// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: multi-source pipeline hazard controller driving per-stage stall, bubble and flush enables.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   i_req_cycles      : per-channel stall length (CNT_W bits each, 0 = no request)
//   i_req_stage       : per-channel originating stage (STG_W bits each, clamped to N_STAGES-1)
//   i_flush           : branch resolved taken; kill stages younger than i_flush_stage
//   i_flush_stage     : resolving stage; stages 0..i_flush_stage-1 are killed
//   o_stall_r         : registered per-stage hold enables
//   o_bubble_r        : registered per-stage bubble-insert enables
//   o_flush_r         : registered per-stage kill pulses
//   o_busy            : combinational, any channel counter non-zero
//   o_stall_cycles    : saturating count of stalled cycles (only with STALL_CTRL_PERF_EN defined)
module pipe_stall_ctrl #(
    parameter int N_STAGES = 4,
    parameter int N_SRC = 2,
    parameter int CNT_W = 4,
    localparam int STG_W = $clog2(N_STAGES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC*CNT_W-1:0]   i_req_cycles,
    input  logic [N_SRC*STG_W-1:0]   i_req_stage,
    input  logic                     i_flush,
    input  logic [STG_W-1:0]         i_flush_stage,
    output logic [N_STAGES-1:0]      o_stall_r,
    output logic [N_STAGES-1:0]      o_bubble_r,
    output logic [N_STAGES-1:0]      o_flush_r,
    output logic                     o_busy
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0]              o_stall_cycles
`endif
);
    logic [CNT_W-1:0] cnt [N_SRC];
    logic [CNT_W-1:0] cnt_nx [N_SRC];
    logic [CNT_W-1:0] req [N_SRC];
    logic [STG_W-1:0] stg [N_SRC];
    logic [STG_W-1:0] stg_nx [N_SRC];
    logic [STG_W-1:0] rs [N_SRC];
    logic [N_STAGES-1:0] stall_nx, bubble_nx, flush_nx;
    logic any_active;
    logic [STG_W-1:0] front;

    // A channel is killed when the stage it would hold after this edge (new request or
    // the one already held) is younger than the resolving branch.
    always_comb begin
        for (int c = 0; c < N_SRC; c++) begin
            req[c] = i_req_cycles[c*CNT_W +: CNT_W];
            rs[c] = i_req_stage[c*STG_W +: STG_W];
            stg_nx[c] = req[c] == '0 ? stg[c] :
                        int'(rs[c]) >= N_STAGES ? STG_W'(N_STAGES - 1) : rs[c];
            cnt_nx[c] = (i_flush && stg_nx[c] < i_flush_stage) ? '0 :
                        req[c] != '0 ? req[c] :
                        cnt[c] != '0 ? cnt[c] - 1'b1 : '0;
        end
    end

    // Frontier is the oldest stage among active channels; everything at or younger
    // holds, and the stage just past it takes a bubble.
    always_comb begin
        any_active = 1'b0;
        front = '0;
        for (int c = 0; c < N_SRC; c++)
            if (cnt[c] != '0) begin
                any_active = 1'b1;
                front = stg[c] > front ? stg[c] : front;
            end
        for (int s = 0; s < N_STAGES; s++) begin
            flush_nx[s] = i_flush && s < int'(i_flush_stage);
            stall_nx[s] = any_active && s <= int'(front) && !flush_nx[s];
            bubble_nx[s] = any_active && s == int'(front) + 1 && !flush_nx[s];
        end
    end

    assign o_busy = any_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_SRC; c++) begin
                cnt[c] <= '0;
                stg[c] <= '0;
            end
            o_stall_r <= '0;
            o_bubble_r <= '0;
            o_flush_r <= '0;
        end else begin
            for (int c = 0; c < N_SRC; c++) begin
                cnt[c] <= cnt_nx[c];
                stg[c] <= stg_nx[c];
            end
            o_stall_r <= stall_nx;
            o_bubble_r <= bubble_nx;
            o_flush_r <= flush_nx;
        end
    end

`ifdef STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_stall_cycles <= '0;
        else if (stall_nx != '0 && o_stall_cycles != 32'hFFFF_FFFF)
            o_stall_cycles <= o_stall_cycles + 32'd1;
    end
`endif
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Parametrised pipeline hazard controller. It generalises the single-source, all-stage stall counter to N_SRC independent multi-cycle stall sources and N_STAGES stages, with stage-selective stall, bubble injection and partial flush. It sits beside the pipeline, takes stall requests from ID/MEM/multi-cycle units and a branch-resolve flush, and drives per-stage stall, bubble and flush enables.

Parameters:
N_STAGES, 4, number of pipeline stages; index 0 = youngest (ID), N_STAGES-1 = oldest (WB); legal range 2..16.
N_SRC, 2, number of independent stall-request channels; legal range 1..8.
CNT_W, 4, width of each stall-cycle count.
STG_W, $clog2(N_STAGES), derived localparam, not overridable.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
i_req_cycles  in  N_SRC*CNT_W  per-channel stall cycle count; channel c occupies bits [c*CNT_W +: CNT_W]; 0 = no request
i_req_stage  in  N_SRC*STG_W  per-channel originating stage index, same packing
i_flush  in  1  branch condition met; kill younger stages
i_flush_stage  in  STG_W  stage where the branch resolved; stages 0..i_flush_stage-1 are killed
o_stall_r  out  N_STAGES  per-stage hold enable, registered
o_bubble_r  out  N_STAGES  per-stage bubble-insert enable, registered
o_flush_r  out  N_STAGES  per-stage kill enable, registered, one-cycle pulse
o_busy  out  1  combinational OR of all channel counters != 0

Behaviour:
- State per channel c: cnt[c] (CNT_W), stg[c] (STG_W). Channel active = cnt[c] != 0.
- Clamping: i_req_stage values >= N_STAGES are treated as N_STAGES-1 when captured.
- Channel update priority at each posedge, highest first:
  - rst: cnt = 0, stg = 0.
  - i_flush and captured-or-held stage < i_flush_stage: cnt = 0. A request arriving the same cycle into a killed stage is dropped.
  - i_req_cycles[c] != 0: cnt = request, stg = clamped i_req_stage. A request on an active channel overwrites it.
  - cnt != 0: cnt = cnt - 1. No wrap below 0.
- Frontier F = max stg[c] over active channels, using pre-edge state.
- Registered outputs, computed from pre-edge counter state:
  - o_stall_r[s] = any_active && s <= F.
  - o_bubble_r[F+1] = any_active && F+1 < N_STAGES; all other bubble bits 0.
  - o_flush_r[s] = i_flush && s < i_flush_stage.
- Flush priority: for every s with o_flush_r[s] = 1, o_stall_r[s] and o_bubble_r[s] are forced to 0 in the same cycle.
- Latency:
  - Request in cycle t loads cnt at edge t+1.
  - o_stall_r rises at edge t+2 and stays high for exactly N cycles, where N = request.
  - o_flush_r is high for the single cycle after the i_flush edge.
- Multiple active channels: the stall covers the oldest frontier. When that channel expires, F drops to the next active channel's stage on the following output update.
- i_flush_stage = 0: no stage is killed and no counter is cleared. i_flush_stage >= N_STAGES kills all stages.
- Reset mid-operation: all outputs are 0 at the first edge with rst=1; all counters are cleared.
- Reset values: o_stall_r = 0, o_bubble_r = 0, o_flush_r = 0, o_busy = 0.

Optional Feature:
Macro STALL_CTRL_PERF_EN.
- Defined: adds output o_stall_cycles (32 bits), reset to 0.
  - Increments on every edge where the new o_stall_r is non-zero.
  - Saturates at 32'hFFFF_FFFF.
  - Not cleared by i_flush.
- Undefined: port and counter are absent; remaining behaviour is identical.

Test Plan:
1. Reset, then channel 0 requests 3 cycles at stage 2 (N_STAGES=4) -> o_stall_r = 4'b0111 for exactly 3 cycles starting 2 edges after the request; o_bubble_r = 4'b1000 over the same cycles; then all 0.
2. Channel 0 requests 4 at stage 1 and channel 1 requests 2 at stage 3 in the same cycle -> o_stall_r = 4'b1111 for 2 cycles, then 4'b0011 for 2 cycles; o_bubble_r = 4'b0000, then 4'b0100.
3. Channel 0 is active at stage 1 with cnt=3, then i_flush with i_flush_stage=2 -> o_flush_r = 4'b0011 for one cycle; the channel is cleared; o_stall_r = 0 on the following cycle.
4. Channel 1 is active at stage 3, then i_flush with i_flush_stage=2 -> channel 1 keeps counting; o_flush_r = 4'b0011; o_stall_r[1:0] is forced to 0 during the flush cycle.
5. Request of 5 re-issued on an active channel with cnt=2 -> the counter reloads to 5; stall lasts 5 more cycles; request value 0 has no effect; i_req_stage=7 is clamped to 3.
6. Assert rst while two channels are active -> all outputs and o_busy are 0 at the next edge; with STALL_CTRL_PERF_EN, o_stall_cycles = 0, and after scenario 1 it equals 3.
